encoder_4_2_seq: RTL
====================

Name: encoder_4_2_seq

Overview:
- Sequential 4-to-2 encoder. It is the inverse partner of the team's 2-to-4 decoder.
- Collects one-hot or multi-hot event requests on `req[3:0]` into a pending register.
- Issues them one at a time as a 2-bit index on a registered valid/ready output.
- Sits between event sources (interrupt lines, select strobes) and a consumer that re-expands the index with the decoder.

Parameters:
- NUM_IN, 4, number of request lines. Fixed at 4; 2 is not supported.
- CODE_W, 2, output index width. Must equal clog2(NUM_IN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  request-capture enable. When 0, `req` is ignored.
- req  input  NUM_IN  request lines. Each bit is sampled at every rising edge while `en`=1.
- code  output  CODE_W  encoded index of the issued request.
- valid  output  1  `code` holds an un-accepted index.
- ready  input  1  consumer accepts `code` when `valid` & `ready` at the clock edge.
- pending  output  NUM_IN  registered pending-request bits not yet moved to the output.
- busy  output  1  |pending | valid.
- overflow  output  1  sticky flag: a request merged into an already-pending bit.
- ovf_clr  input  1  clears `overflow` (synchronous).

Behaviour:
- Reset (rst_n=0 at an edge): valid=0, code=0, pending=0, overflow=0.
  - Reset mid-operation discards all pending and held requests.
  - No output change occurs until the edge after rst_n returns to 1.
- Effective request set: `cand = pending | (en ? req : 0)`.
- Load condition: `load = (!valid || ready) && (cand != 0)`.
- On load:
  - `code <= sel(cand)`, `valid <= 1`.
  - The selected bit is cleared from the pending update.
- If `ready` & `valid` & (cand == 0): `valid <= 0`. `code` holds its last value.
- If `valid` & !`ready`: `code`/`valid` are held stable. No load occurs.
- Pending update: `pending <= cand & ~(load ? onehot(sel(cand)) : 0)`.
- Latency: `req` asserted before edge N with an empty output gives valid=1 with its code after edge N (1 cycle).
- Throughput: one index per cycle while `ready`=1.
- Default selection (fixed priority): the highest set index wins (3 > 2 > 1 > 0).
- Simultaneous/boundary cases:
  - A request for the index currently held in `code` (valid=1) is stored in `pending` and issued again later. It is not lost.
  - `en` & `req[i]` & `pending[i]` (registered value) sets `overflow` <= 1. The two requests collapse into one.
  - `ovf_clr` has priority over a same-cycle overflow set: the result is 0.
  - `en`=0: `pending` still drains normally. No new bits are captured.
  - All 4 bits requested in one cycle are issued over 4 consecutive cycles with `ready`=1: codes 3,2,1,0.
- No combinational path from `ready` to `valid` or `code`.

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN.
- Defined:
  - Adds a 2-bit priority pointer `last`, reset to 3.
  - `sel` picks the first set bit of `cand` starting at (last+1) mod 4, wrapping.
  - `last <= sel` on each load.
- Undefined: fixed highest-index priority as above. No pointer register exists.

Decomposition:
- Package `encoder_pkg`:
  - constants NUM_IN=4, CODE_W=2.
  - typedef `req_vec_t` (logic [NUM_IN-1:0]), typedef `code_t` (logic [CODE_W-1:0]).
  - function `onehot(code_t)` returning `req_vec_t`.
- Sub-module `prio_sel_4`:
  - combinational selector.
  - inputs cand[3:0], ptr[1:0] (ptr ignored without ENCODER_ROUND_ROBIN_EN).
  - outputs sel[1:0], any.

Test Plan:
- Reset: rst_n=0 for 2 cycles while req=4'hF, en=1 → valid=0, code=0, pending=0, overflow=0. First valid appears 1 cycle after release.
- Single request: req=4'b0100 for one cycle, ready=1 → next cycle valid=1, code=2'b10, then valid=0. Pending stays 0 throughout.
- Burst: req=4'b1111 one cycle, ready=1 → codes 3,2,1,0 on consecutive cycles. With ENCODER_ROUND_ROBIN_EN the order is 0,1,2,3.
- Backpressure: req=4'b0011, ready=0 for 3 cycles → code=1 held stable, pending=4'b0001. Raise ready → code 0 follows.
- Overflow: req=4'b0001 with ready=0 at cycles 0,1,2 → overflow=1 after cycle 2's edge. ovf_clr=1 → overflow=0.
- Enable gating: en=0, req=4'b1000 → no capture, valid stays 0. An existing pending bit still issues.

Source files
------------

// File: rtl/encoder_4_2_seq_pkg.sv
// Shared types and helpers for the sequential 4-to-2 encoder.
// Optional build macro: ENCODER_ROUND_ROBIN_EN (round-robin selection).
package encoder_pkg;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned CODE_W = 2;

    typedef logic [NUM_IN-1:0] req_vec_t;
    typedef logic [CODE_W-1:0] code_t;

    // Expand an index back into its request-line position
    function automatic req_vec_t onehot(code_t c);
        req_vec_t v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/encoder_4_2_seq_if.sv
// Issue-side handshake of the encoder: index plus valid/ready.
// Optional build macro: ENCODER_ROUND_ROBIN_EN (does not affect this file).
interface encoder_4_2_seq_if;
    import encoder_pkg::*;

    code_t code;
    logic  valid;
    logic  ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);

endinterface

// File: rtl/encoder_4_2_seq_prio_sel_4.sv
// Combinational 4-way request selector.
// Optional build macro: ENCODER_ROUND_ROBIN_EN selects round-robin from ptr+1;
// otherwise the highest set index wins and ptr is ignored.
module prio_sel_4
    import encoder_pkg::*;
(
    input  req_vec_t cand,
    input  code_t    ptr,
    output code_t    sel,
    output logic     any
);

`ifdef ENCODER_ROUND_ROBIN_EN
    // Scan offsets from farthest to nearest so the nearest set bit after ptr wins
    always_comb begin
        sel = '0;
        any = |cand;
        for (int unsigned i = NUM_IN; i > 0; i--) begin
            if (cand[code_t'(ptr + code_t'(i))]) begin
                sel = code_t'(ptr + code_t'(i));
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Ascending scan: the highest set index overwrites lower ones
    always_comb begin
        sel = '0;
        any = |cand;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (cand[i]) begin
                sel = code_t'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/encoder_4_2_seq.sv
// Sequential 4-to-2 encoder: gathers requests into a pending register and
// issues them one index at a time over a registered valid/ready output.
// Optional build macro: ENCODER_ROUND_ROBIN_EN (round-robin pointer `last`).
module encoder_4_2_seq
    import encoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  req_vec_t                 req,
    input  logic                     ovf_clr,
    encoder_4_2_seq_if.master        bus,
    output req_vec_t                 pending,
    output logic                     busy,
    output logic                     overflow
);

    code_t    code_q, code_d;
    logic     valid_q, valid_d;
    req_vec_t pending_q, pending_d;
    logic     overflow_q, overflow_d;

    req_vec_t req_eff;
    req_vec_t cand;
    code_t    sel;
    code_t    ptr;
    logic     any;
    logic     load;

`ifdef ENCODER_ROUND_ROBIN_EN
    code_t last_q, last_d;
    assign ptr = last_q;
`else
    assign ptr = '1;
`endif

    assign req_eff = en ? req : '0;
    assign cand    = pending_q | req_eff;

    prio_sel_4 u_sel (
        .cand (cand),
        .ptr  (ptr),
        .sel  (sel),
        .any  (any)
    );

    // Next-state: load the output slot when free or draining, else hold
    always_comb begin
        load       = (!valid_q || bus.ready) && any;
        code_d     = code_q;
        valid_d    = valid_q;
        pending_d  = cand;
        overflow_d = overflow_q;
`ifdef ENCODER_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        if (load) begin
            code_d    = sel;
            valid_d   = 1'b1;
            pending_d = cand & ~onehot(sel);
`ifdef ENCODER_ROUND_ROBIN_EN
            last_d    = sel;
`endif
        end else if (valid_q && bus.ready) begin
            valid_d = 1'b0;
        end
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end else if (|(req_eff & pending_q)) begin
            overflow_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q     <= '0;
            valid_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
`ifdef ENCODER_ROUND_ROBIN_EN
            last_q     <= '1;
`endif
        end else begin
            code_q     <= code_d;
            valid_q    <= valid_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
`ifdef ENCODER_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = (|pending_q) | valid_q;

endmodule
